// File: rtl/dual_ram_fifo_ctrl.sv
// FIFO controller driving both ports of a dual_ram: valid/ready push and pop streams,
// with a one-word registered show-ahead output stage fed by a one-cycle RAM read.
module dual_ram_fifo_ctrl #(
   parameter int RAM_WIDTH = 8,
   parameter int RAM_DEPTH = 16,
   parameter int ADDR_SIZE = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_valid,
   input  logic [RAM_WIDTH-1:0] wr_data,
   output logic                 wr_ready,
   output logic                 rd_valid,
   output logic [RAM_WIDTH-1:0] rd_data,
   input  logic                 rd_ready,
   output logic [ADDR_SIZE:0]   count,
   output logic                 ram_write,
   output logic [ADDR_SIZE-1:0] ram_wr_addr,
   output logic [RAM_WIDTH-1:0] ram_data_in,
   output logic                 ram_read,
   output logic [ADDR_SIZE-1:0] ram_rd_addr,
   input  logic [RAM_WIDTH-1:0] ram_data_out
);

   typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

   localparam logic [ADDR_SIZE:0]   DEPTH_C = RAM_DEPTH[ADDR_SIZE:0];
   localparam logic [ADDR_SIZE:0]   CNT_ONE = {{ADDR_SIZE{1'b0}}, 1'b1};
   localparam logic [ADDR_SIZE-1:0] PTR_ONE = {{(ADDR_SIZE-1){1'b0}}, 1'b1};

   state_t               state_q, state_d;
   logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_SIZE:0]   mem_count_q, mem_count_d;
   logic [RAM_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                 push, issue;

   always_comb begin
      wr_ready    = !reset && (mem_count_q < DEPTH_C);
      push        = wr_valid && wr_ready;
      issue       = 1'b0;
      state_d     = state_q;
      rd_data_d   = rd_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      mem_count_d = mem_count_q;

      // A fetch only sees words committed at an earlier edge, so a same-cycle push is never read.
      case (state_q)
         IDLE: begin
            if (mem_count_q != '0) begin
               issue   = 1'b1;
               state_d = FETCH;
            end
         end
         FETCH: begin
            state_d   = HOLD;
            rd_data_d = ram_data_out;
         end
         HOLD: begin
            if (rd_ready) begin
               if (mem_count_q != '0) begin
                  issue   = 1'b1;
                  state_d = FETCH;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (reset) issue = 1'b0;

      if (push)  wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (issue) rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, issue})
         2'b10:   mem_count_d = mem_count_q + CNT_ONE;
         2'b01:   mem_count_d = mem_count_q - CNT_ONE;
         default: mem_count_d = mem_count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         mem_count_q <= '0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_count_q <= mem_count_d;
         rd_data_q   <= rd_data_d;
      end
   end

   assign rd_valid    = (state_q == HOLD);
   assign rd_data     = rd_data_q;
   assign count       = (state_q == IDLE) ? mem_count_q : mem_count_q + CNT_ONE;
   assign ram_write   = push;
   assign ram_wr_addr = wr_ptr_q;
   assign ram_data_in = wr_data;
   assign ram_read    = issue;
   assign ram_rd_addr = rd_ptr_q;

endmodule

// File: tb/tb_dual_ram_fifo_ctrl.sv
// Bench for dual_ram_fifo_ctrl: behavioural RAM, queue-based FIFO model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_dual_ram_fifo_ctrl;

   localparam int W = 8;
   localparam int D = 16;
   localparam int A = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         wr_valid = 1'b0;
   logic [W-1:0] wr_data = '0;
   logic         wr_ready;
   logic         rd_valid;
   logic [W-1:0] rd_data;
   logic         rd_ready = 1'b0;
   logic [A:0]   count;
   logic         ram_write;
   logic [A-1:0] ram_wr_addr;
   logic [W-1:0] ram_data_in;
   logic         ram_read;
   logic [A-1:0] ram_rd_addr;
   logic [W-1:0] ram_data_out = '0;

   int total = 0;
   int bad   = 0;

   dual_ram_fifo_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_SIZE(A)) dut (
      .clk(clk), .reset(reset),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
      .count(count),
      .ram_write(ram_write), .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in),
      .ram_read(ram_read), .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out)
   );

   always #5 clk = ~clk;

   // Behavioural dual_ram: data_out valid the cycle after a read.
   logic [W-1:0] ram [D];
   always @(posedge clk) begin
      if (ram_write) ram[ram_wr_addr] <= ram_data_in;
      if (ram_read)  ram_data_out     <= ram[ram_rd_addr];
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: queue of committed words, one in-flight word, one held word.
   logic [W-1:0] q[$];
   bit           mvalid = 0;
   bit           inflight = 0, holding = 0;
   logic [W-1:0] fetch_data = '0, hold_data = '0;
   logic [A-1:0] wp = '0, rp = '0;
   bit           e_wr_ready, e_push, e_read;
   int           e_count;

   always @(negedge clk) begin
      e_wr_ready = !reset && (q.size() < D);
      e_push     = e_wr_ready && wr_valid;
      e_read     = !reset && (q.size() > 0) && !inflight && (!holding || rd_ready);
      e_count    = q.size() + int'(inflight) + int'(holding);
      if (mvalid) begin
         chk("wr_ready",    wr_ready,    e_wr_ready);
         chk("ram_write",   ram_write,   e_push);
         chk("ram_wr_addr", ram_wr_addr, wp);
         chk("ram_data_in", ram_data_in, wr_data);
         chk("ram_read",    ram_read,    e_read);
         chk("ram_rd_addr", ram_rd_addr, rp);
         chk("rd_valid",    rd_valid,    holding);
         chk("rd_data",     rd_data,     hold_data);
         chk("count",       count,       e_count);
      end
      if (reset) begin
         q.delete();
         inflight  = 0;
         holding   = 0;
         hold_data = '0;
         wp        = '0;
         rp        = '0;
         mvalid    = 1;
      end else if (mvalid) begin
         if (inflight) begin
            holding   = 1;
            hold_data = fetch_data;
            inflight  = 0;
         end else if (holding && rd_ready) begin
            holding = 0;
         end
         if (e_read) begin
            fetch_data = q.pop_front();
            inflight   = 1;
            rp++;
         end
         if (e_push) begin
            q.push_back(wr_data);
            wp++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [W-1:0] d);
      bit done = 0;
      int n = 0;
      wr_valid = 1'b1;
      wr_data  = d;
      while (!done && n < 100) begin
         @(negedge clk);
         if (wr_ready) done = 1;
         step();
         n++;
      end
      wr_valid = 1'b0;
      if (!done) chk("push_timeout", 0, 1);
   endtask

   task automatic wait_valid();
      int n = 0;
      @(negedge clk);
      while (!rd_valid && n < 50) begin
         step();
         @(negedge clk);
         n++;
      end
      if (!rd_valid) chk("wait_valid_timeout", 0, 1);
   endtask

   initial begin
      // Reset for two cycles.
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_ram_read", ram_read, 0);
      chk("rst_ram_write", ram_write, 0);
      step();

      // Single word latency.
      wr_valid = 1'b1; wr_data = 8'hA5;
      @(negedge clk);
      chk("sw_ram_write", ram_write, 1);
      chk("sw_wr_addr", ram_wr_addr, 0);
      step(); wr_valid = 1'b0;
      @(negedge clk);
      chk("sw_ram_read", ram_read, 1);
      chk("sw_rd_addr", ram_rd_addr, 0);
      chk("sw_count1", count, 1);
      step();
      @(negedge clk);
      chk("sw_not_valid", rd_valid, 0);
      chk("sw_count2", count, 1);
      step();
      @(negedge clk);
      chk("sw_valid", rd_valid, 1);
      chk("sw_data", rd_data, 8'hA5);
      chk("sw_count3", count, 1);
      rd_ready = 1'b1;
      step(); rd_ready = 1'b0;
      @(negedge clk);
      chk("sw_count_after_pop", count, 0);
      step();

      // Fill with the output stalled.
      for (int d = 8'h10; d <= 8'h20; d++) push(W'(d));
      wr_valid = 1'b1; wr_data = 8'h21;
      @(negedge clk);
      chk("fill_wr_ready", wr_ready, 0);
      chk("fill_count", count, 17);
      chk("fill_head_valid", rd_valid, 1);
      chk("fill_head_data", rd_data, 8'h10);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         chk("fill_stalled", ram_write, 0);
      end

      // Drain across the pointer wrap while pushing more.
      rd_ready = 1'b1;
      for (int d = 8'h21; d <= 8'h28; d++) push(W'(d));
      begin
         int n = 0;
         @(negedge clk);
         while (count != 0 && n < 300) begin
            step();
            @(negedge clk);
            n++;
         end
         chk("drain_empty", count, 0);
      end
      rd_ready = 1'b0;
      step();

      // Backpressure: output held while pushes continue.
      push(8'h55); push(8'h66); push(8'h77);
      wait_valid();
      chk("bp_head", rd_data, 8'h55);
      step();
      for (int i = 0; i < 5; i++) begin
         wr_valid = 1'b1; wr_data = W'($urandom);
         @(negedge clk);
         chk("bp_data_stable", rd_data, 8'h55);
         chk("bp_no_read", ram_read, 0);
         step();
      end
      wr_valid = 1'b0;

      // Reset mid-stream.
      reset = 1'b1; step(); reset = 1'b0;
      for (int d = 1; d <= 6; d++) push(W'(d));
      reset = 1'b1; step(); reset = 1'b0;
      wr_valid = 1'b1; wr_data = 8'h3C;
      @(negedge clk);
      chk("mr_count", count, 0);
      chk("mr_rd_valid", rd_valid, 0);
      chk("mr_ram_write", ram_write, 1);
      chk("mr_wr_addr", ram_wr_addr, 0);
      step(); wr_valid = 1'b0;
      wait_valid();
      chk("mr_data", rd_data, 8'h3C);
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 1200; i++) begin
         wr_valid = ($urandom_range(0, 3) != 0);
         wr_data  = W'($urandom);
         rd_ready = (i < 600) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         reset    = ($urandom_range(0, 149) == 0);
         step();
      end
      reset = 1'b0; wr_valid = 1'b0; rd_ready = 1'b1;
      repeat (60) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
